// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for the lane-masked skid pipeline stage.
// The producer/consumer side uses master; the stage itself uses slave.
interface pipe_stage_skid_if #(
    parameter int W     = 8,
    parameter int LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W*LANES-1:0]   in_data;
    logic [LANES-1:0]     in_lane_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [W*LANES-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_lane_en, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_lane_en, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Lane-masked pipeline register with valid/ready handshake and a 1-entry skid buffer.
// Optional stall counter enabled by defining PIPE_SKID_STATS_EN.
module pipe_stage_skid #(
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
`ifdef PIPE_SKID_STATS_EN
    output logic [CNT_W-1:0] stall_count,
`endif
    pipe_stage_skid_if.slave bus
);
    localparam int DW = W * LANES;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t           state;
    state_t           next_state;
    logic [DW-1:0]    main_q;
    logic [DW-1:0]    main_d;
    logic [DW-1:0]    skid_q;
    logic [DW-1:0]    skid_d;
    logic [LANES-1:0] skid_mask_q;
    logic [LANES-1:0] skid_mask_d;
    logic             in_fire;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0]    base,
                                            input logic [DW-1:0]    d,
                                            input logic [LANES-1:0] m);
        logic [DW-1:0] r;
        r = base;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) r[i*W +: W] = d[i*W +: W];
        end
        return r;
    endfunction

    // Handshake outputs depend only on the state register, never on inputs.
    assign bus.in_ready  = (state != SKID);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = main_q;
    assign in_fire       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            skid_mask_q <= '0;
        end else begin
            state       <= next_state;
            main_q      <= main_d;
            skid_q      <= skid_d;
            skid_mask_q <= skid_mask_d;
        end
    end

    always_comb begin
        next_state  = state;
        main_d      = main_q;
        skid_d      = skid_q;
        skid_mask_d = skid_mask_q;
        if (flush) begin
            // Squash drops only validity; data registers keep the merge base.
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        next_state = FULL;
                        main_d     = merge(main_q, bus.in_data, bus.in_lane_en);
                    end
                end
                FULL: begin
                    if (in_fire && bus.out_ready) begin
                        main_d = merge(main_q, bus.in_data, bus.in_lane_en);
                    end else if (in_fire) begin
                        next_state  = SKID;
                        skid_d      = bus.in_data;
                        skid_mask_d = bus.in_lane_en;
                    end else if (bus.out_ready) begin
                        next_state = EMPTY;
                    end
                end
                SKID: begin
                    if (bus.out_ready) begin
                        next_state = FULL;
                        main_d     = merge(main_q, skid_q, skid_mask_q);
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

`ifdef PIPE_SKID_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (bus.out_valid && !bus.out_ready && !flush && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule
